// File: rtl/adder_seq_pkg.sv
// Shared definitions for the digit-serial adder: FSM encoding and counter sizing.
package adder_seq_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    // Width of a counter that indexes n chunks; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/adder_1bit.sv
// Single-bit full adder, the leaf cell of the chunk carry cascade.
module adder_1bit (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/adder_chunk.sv
// Combinational CHUNK-bit ripple adder built from adder_1bit cells.
// Cmsb exposes the carry into the top bit so the caller can derive signed overflow.
module adder_chunk #(
    parameter int unsigned CHUNK = 8
) (
    input  logic [CHUNK-1:0] A,
    input  logic [CHUNK-1:0] B,
    input  logic             Ci,
    output logic [CHUNK-1:0] S,
    output logic             Co,
    output logic             Cmsb
);

    logic [CHUNK:0] c;

    assign c[0] = Ci;

    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
        adder_1bit u_bit (
            .a  (A[i]),
            .b  (B[i]),
            .ci (c[i]),
            .s  (S[i]),
            .co (c[i+1])
        );
    end

    assign Co   = c[CHUNK];
    assign Cmsb = c[CHUNK-1];

endmodule

// File: rtl/adder_seq32.sv
// Digit-serial adder/subtractor: WIDTH-bit operands processed CHUNK bits per clock,
// LS chunk first, with valid/ready handshakes on both sides.
// Optional build macro: ADDER_SEQ_SATURATE_EN replaces S with the saturated value on overflow.
module adder_seq32
    import adder_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Co,
    output logic             Ov
);

    localparam int unsigned N  = WIDTH / CHUNK;
    localparam int unsigned IW = cnt_width(N);

`ifdef ADDER_SEQ_SATURATE_EN
    localparam logic [WIDTH-1:0] SatPos = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SatNeg = {1'b1, {(WIDTH-1){1'b0}}};
`endif

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             co_q, co_d;
    logic             ov_q, ov_d;

    logic [CHUNK-1:0] a_chunk, b_chunk, sum_chunk;
    logic             co_chunk, cmsb_chunk;
    logic             last_chunk;

    // Chunk multiplexer: select the operand slice addressed by the chunk counter.
    always_comb begin
        a_chunk = a_q[idx_q*CHUNK +: CHUNK];
        b_chunk = b_q[idx_q*CHUNK +: CHUNK];
    end

    adder_chunk #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .A    (a_chunk),
        .B    (b_chunk),
        .Ci   (carry_q),
        .S    (sum_chunk),
        .Co   (co_chunk),
        .Cmsb (cmsb_chunk)
    );

    assign last_chunk = (idx_q == IW'(N - 1));

    // Next-state and datapath update for the IDLE/RUN/DONE sequence.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        s_d     = s_q;
        co_d    = co_q;
        ov_d    = ov_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d     = A;
                    // Subtraction is A + ~B + 1: invert B here, inject the +1 as carry-in.
                    b_d     = Sub ? ~B : B;
                    carry_d = Sub;
                    idx_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                s_d[idx_q*CHUNK +: CHUNK] = sum_chunk;
                carry_d                   = co_chunk;
                idx_d                     = idx_q + IW'(1);
                if (last_chunk) begin
                    co_d    = co_chunk;
                    ov_d    = co_chunk ^ cmsb_chunk;
`ifdef ADDER_SEQ_SATURATE_EN
                    if (co_chunk ^ cmsb_chunk) begin
                        s_d = a_q[WIDTH-1] ? SatNeg : SatPos;
                    end
`endif
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            s_q     <= '0;
            co_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            s_q     <= s_d;
            co_q    <= co_d;
            ov_q    <= ov_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign S         = s_q;
    assign Co        = co_q;
    assign Ov        = ov_q;

endmodule

// File: doc/adder_seq32.md
# adder_seq32

Multi-cycle, digit-serial adder/subtractor. It processes a `WIDTH`-bit operand pair `CHUNK` bits per clock, starting from the least-significant chunk, and reports sum, carry-out and signed overflow. It trades latency for a short carry chain, and is the clocked successor to the combinational 32-bit cascaded adder in the lab datapath. Operands enter and results leave through valid/ready handshakes.

## Interface
- `WIDTH`, default 32: operand/result width in bits.
- `CHUNK`, default 8: bits processed per cycle.
  - `WIDTH % CHUNK` must be 0.
  - `N = WIDTH/CHUNK` is the cycle count per operation.
- `clk` input, 1 bit: sole clock, rising edge.
- `rstb` input, 1 bit: synchronous, active-low reset.
- `in_valid` input, 1 bit: operands and `Sub` are valid.
- `in_ready` output, 1 bit: block can accept an operation.
- `A`, `B` input, WIDTH bits: operands (two's complement for `Ov`).
- `Sub` input, 1 bit: 0 selects A+B, 1 selects A−B.
- `out_valid` output, 1 bit: result is valid.
- `out_ready` input, 1 bit: consumer accepts the result.
- `S` output, WIDTH bits: result.
- `Co` output, 1 bit: carry out of bit WIDTH-1. For subtraction, 1 means no borrow.
- `Ov` output, 1 bit: signed overflow.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`: latch A, B and Sub, clear the chunk index, set carry = Sub, go to RUN.
  - B is latched inverted when Sub=1.
- RUN:
  - Each cycle, chunk k (bits k·CHUNK … k·CHUNK+CHUNK-1) is added with the stored carry.
  - The chunk sum is written into S register bits of chunk k, and the carry register is updated.
  - In the final chunk, the carry into bit WIDTH-1 is captured as c_msb.
  - After chunk N-1, go to DONE.
  - `in_ready`=0. `in_valid` is ignored.
- DONE:
  - `out_valid`=1.
  - S, Co and Ov are held stable until `out_ready`=1, then go to IDLE.
  - `in_ready`=0.
- Outputs:
  - Co = final carry.
  - Ov = final carry XOR c_msb.
  - Arithmetic is modulo 2^WIDTH. There is no exception path.
- Outputs are registered. S is not guaranteed meaningful outside DONE. The bench checks S only when `out_valid`=1.
- Reset (`rstb`=0 at any rising edge, in any state):
  - State goes to IDLE and any in-flight operation is discarded.
  - S=0, Co=0, Ov=0, out_valid=0.
  - in_ready=1 from the first post-reset cycle.
- CHUNK=WIDTH is legal: one RUN cycle. CHUNK=1 is legal: fully bit-serial.

## Timing
- Accept at rising edge E0 (IDLE, in_valid=1). RUN occupies the N cycles following E0.
- `out_valid` rises after edge E0+N. Accept-to-result latency is N cycles.
- Result handshake completes at the first edge Ed in DONE with out_ready=1. The state is IDLE after Ed.
- The next accept is possible at the following edge. Minimum issue interval is N+2 cycles.
- A/B/Sub need to be stable only at the accept edge.
- out_ready held low stalls indefinitely with no change in outputs.

## Configuration
- `ADDER_SEQ_SATURATE_EN` defined:
  - When Ov=1, S is replaced by the saturated value.
  - Saturated value is 0 followed by WIDTH-1 ones (max positive) if latched A[WIDTH-1]=0.
  - Otherwise it is 1 followed by WIDTH-1 zeros (min negative).
  - Ov is still reported as 1. Co is unaffected.
- Undefined: S is always the wrapped modulo result. The saturation logic is absent.
- Latency is identical in both builds.

## Structure
- Package `adder_seq_pkg`: FSM state encoding (IDLE/RUN/DONE) and a chunk-count width helper function (clog2 of N, minimum 1).
- Sub-module `adder_chunk`:
  - Combinational, parameter CHUNK.
  - Ports A, B, Ci, S, Co, Cmsb (carry into its top bit).
  - Built as a cascade of `adder_1bit` instances.
  - Instantiated once and fed by a chunk multiplexer indexed by the chunk counter.

## Test plan
WIDTH=32, CHUNK=8, N=4 unless stated.
1. Reset, then A=5, B=7, Sub=0 → S=12, Co=0, Ov=0. out_valid rises exactly 4 cycles after the accept edge.
2. Overflow, A=0x7FFFFFFF, B=1, Sub=0:
   - Without macro → S=0x80000000, Ov=1, Co=0.
   - With `ADDER_SEQ_SATURATE_EN` → S=0x7FFFFFFF, Ov=1.
3. Subtraction cases:
   - A=0, B=1, Sub=1 → S=0xFFFFFFFF, Co=0, Ov=0.
   - A=0x80000000, B=1, Sub=1 → S=0x7FFFFFFF, Ov=1 (saturated build → 0x80000000).
4. A=0xFFFFFFFF, B=1, Sub=0 → S=0, Co=1, Ov=0.
   - Repeat with CHUNK=1 (latency 32) and CHUNK=32 (latency 1): identical results.
5. Hold out_ready=0 for 3 cycles in DONE, with in_valid=1 and new operands driven:
   - S/Co/Ov unchanged, in_ready=0, new operands not accepted.
   - After out_ready=1 → IDLE. The next accept yields the new operands' result.
6. Drive rstb=0 for one edge during the 2nd RUN cycle:
   - Next cycle: IDLE, out_valid=0, S=0.
   - The interrupted result never appears.
   - A following A=3, B=4 operation returns S=7.
